// File: rtl/pwm_audio_decoder_if.sv
// Port bundle for pwm_audio_decoder: control/PWM input towards the decoder and
// the recovered-sample / status outputs back to the consumer.
interface pwm_audio_decoder_if #(
  parameter int SAMPLE_BITS = 12
);
  logic                   ena;
  logic                   pwm_in;
  logic [SAMPLE_BITS-1:0] sample;
  logic                   sample_valid;
  logic                   locked;
  logic                   err_timeout;
  logic                   err_period;

  modport master (
    output ena, pwm_in,
    input  sample, sample_valid, locked, err_timeout, err_period
  );

  modport slave (
    input  ena, pwm_in,
    output sample, sample_valid, locked, err_timeout, err_period
  );
endinterface

// File: rtl/pwm_audio_decoder.sv
// Recovers an audio sample from a PWM stream by measuring high time per frame
// (rise to rise). Optional frame-length check enabled by PWM_DEC_PERIOD_CHECK_EN.
module pwm_audio_decoder #(
  parameter int SAMPLE_BITS    = 12,
  parameter int PERIOD_CYCLES  = 4096,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int PERIOD_TOL     = 16
) (
  input  logic               clk,
  input  logic               rst,
  pwm_audio_decoder_if.slave bus
);
  localparam int HW = SAMPLE_BITS + 1;
  localparam int PW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [HW-1:0]          HIGH_MAX = '1;
  localparam logic [SAMPLE_BITS-1:0] SMP_MAX  = '1;
  localparam logic [PW-1:0]          TO_CNT   = PW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             sync_q;
  logic [PW-1:0]          period_cnt_q, period_cnt_d;
  logic [HW-1:0]          high_cnt_q, high_cnt_d;
  logic [SAMPLE_BITS-1:0] sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   err_to_q, err_to_d;
  logic                   err_per_q, err_per_d;
  logic                   s2, rise, per_bad;
  logic [SAMPLE_BITS-1:0] high_sat;

  // sync_q[1] is the synchronized level, sync_q[2] its one-cycle delay
  assign s2   = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign high_sat = (high_cnt_q > HW'(SMP_MAX)) ? SMP_MAX : high_cnt_q[SAMPLE_BITS-1:0];

`ifdef PWM_DEC_PERIOD_CHECK_EN
  localparam logic [PW-1:0] PER_HI = PW'(PERIOD_CYCLES + PERIOD_TOL);
  localparam logic [PW-1:0] PER_LO = PW'(PERIOD_CYCLES - PERIOD_TOL);
  assign per_bad = (period_cnt_q > PER_HI) || (period_cnt_q < PER_LO);
`else
  assign per_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_to_q     <= 1'b0;
      err_per_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], bus.pwm_in};
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      err_to_q     <= err_to_d;
      err_per_q    <= err_per_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    err_to_d     = err_to_q;
    err_per_d    = err_per_q;
    if (!bus.ena) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      locked_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          if (rise) begin
            state_d      = MEASURE;
            period_cnt_d = PW'(1);
            high_cnt_d   = HW'(1);
          end
        end
        MEASURE: begin
          // A rise completes the frame and takes priority over a coincident timeout
          if (rise) begin
            sample_d     = high_sat;
            valid_d      = 1'b1;
            locked_d     = 1'b1;
            period_cnt_d = PW'(1);
            high_cnt_d   = HW'(1);
            if (per_bad) err_per_d = 1'b1;
          end else if (period_cnt_q >= TO_CNT) begin
            sample_d     = s2 ? SMP_MAX : '0;
            valid_d      = 1'b1;
            err_to_d     = 1'b1;
            locked_d     = 1'b0;
            state_d      = IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + PW'(1);
            if (s2 && (high_cnt_q != HIGH_MAX)) high_cnt_d = high_cnt_q + HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.err_timeout  = err_to_q;
  assign bus.err_period   = err_per_q;
endmodule

// File: tb/tb_pwm_audio_decoder.sv
// Scoreboard bench for pwm_audio_decoder: frame stimulus pushes expected strobes,
// a negedge monitor pops and compares each strobe the decoder presents.
module tb_pwm_audio_decoder;
`ifdef PWM_DEC_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  typedef struct {
    logic [11:0] smp;
    bit          lk;
    bit          eto;
    bit          eper;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   prev_h = 0;
  int   prev_p = 0;
  bit   exp_eto = 1'b0;
  bit   exp_eper = 1'b0;
  exp_t q[$];

  pwm_audio_decoder_if #(.SAMPLE_BITS(12)) bus ();

  pwm_audio_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame starting with a pin rise; chk: this rise closes a measured frame,
  // to: the frame is long enough to end in a stuck-level timeout.
  task automatic run_frame(input int h, input int p, input bit chk_rise, input bit to);
    exp_t e;
    bus.pwm_in = 1'b1;
    if (chk_rise) begin
      if (PCHK && (prev_p > 4096 + 16 || prev_p < 4096 - 16)) exp_eper = 1'b1;
      e = '{smp: (prev_h > 4095) ? 12'd4095 : 12'(prev_h), lk: 1'b1, eto: exp_eto,
            eper: exp_eper, cyc: cyc + 3};
      q.push_back(e);
    end
    if (to) begin
      exp_eto = 1'b1;
      e = '{smp: (h > 8192) ? 12'd4095 : 12'd0, lk: 1'b0, eto: 1'b1,
            eper: exp_eper, cyc: cyc + 8195};
      q.push_back(e);
    end
    prev_h = h;
    prev_p = p;
    repeat (h) tick();
    bus.pwm_in = 1'b0;
    repeat (p - h) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.sample_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sample", int'(bus.sample), int'(e.smp));
        chk("locked", int'(bus.locked), int'(e.lk));
        chk("err_timeout", int'(bus.err_timeout), int'(e.eto));
        chk("err_period", int'(bus.err_period), int'(e.eper));
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.pwm_in = 1'b0;
    tick();
    bus.pwm_in = 1'b1;
    tick();
    bus.pwm_in = 1'b0;
    chk("rst_sample", int'(bus.sample), 0);
    chk("rst_valid", int'(bus.sample_valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_err_timeout", int'(bus.err_timeout), 0);
    chk("rst_err_period", int'(bus.err_period), 0);
    rst = 1'b0;
    bus.ena = 1'b1;
    repeat (5) tick();
    chk("idle_locked", int'(bus.locked), 0);

    // steady 25% duty, then duty sweep
    run_frame(1024, 4096, 1'b0, 1'b0);
    repeat (3) run_frame(1024, 4096, 1'b1, 1'b0);
    run_frame(1, 4096, 1'b1, 1'b0);
    run_frame(2048, 4096, 1'b1, 1'b0);
    run_frame(4095, 4096, 1'b1, 1'b0);

    // stuck high, relock, stuck low
    run_frame(8400, 8500, 1'b1, 1'b1);
    chk("stuck_hi_locked", int'(bus.locked), 0);
    run_frame(1024, 4096, 1'b0, 1'b0);
    run_frame(512, 8400, 1'b1, 1'b1);
    chk("stuck_lo_err_timeout", int'(bus.err_timeout), 1);

    // enable dropped mid-frame
    run_frame(1000, 4096, 1'b0, 1'b0);
    run_frame(1024, 2000, 1'b1, 1'b0);
    bus.ena = 1'b0;
    tick();
    chk("ena_drop_locked", int'(bus.locked), 0);
    tick();
    bus.ena = 1'b1;
    run_frame(1000, 4096, 1'b0, 1'b0);

    // frame lengths 4100 (in tolerance) then 4120 (out of tolerance)
    run_frame(1000, 4100, 1'b1, 1'b0);
    run_frame(1000, 4120, 1'b1, 1'b0);
    run_frame(1000, 4096, 1'b1, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 0);
    chk("final_err_period", int'(bus.err_period), PCHK ? 1 : 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
